// File: rtl/hgc_pixel.sv
// MDA/Hercules pixel serialiser: captures a text or graphics cell on load and
// emits one registered pixel per pix_ce, with attribute, cursor and blink decode.
module hgc_pixel (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        load,
  input  logic        gfx_mode,
  input  logic [7:0]  char_code,
  input  logic [7:0]  char_bits,
  input  logic [7:0]  attr,
  input  logic [15:0] gfx_word,
  input  logic        de,
  input  logic        cursor,
  input  logic        ul_row,
  input  logic        blink_en,
  input  logic        vsync,
  output logic        video,
  output logic        intensity
);

  logic [4:0]  frame;
  logic        vsync_q;
  logic [15:0] shift_q;
  logic [3:0]  remain_q;
  logic        mode_q, de_q, cursor_q, ul_q, blink_q;
  logic [7:0]  attr_q;

  logic        dot8;
  logic [15:0] load_bits;
  logic        c_mode, c_de, c_cursor, c_ul, c_blink, c_dot;
  logic [7:0]  c_attr;
  logic        invisible, reverse, underline;
  logic        fg_v, fg_i, bg_v, bg_i;
  logic        pix_v, pix_i;

  // Text cells occupy the top 9 bits of the shifter; the 9th dot only
  // extends into the gap for the line-drawing range 0xC0-0xDF.
  assign dot8      = (char_code[7:5] == 3'b110) & char_bits[0];
  assign load_bits = gfx_mode ? gfx_word : {char_bits, dot8, 7'b0};

  always_comb begin
    c_mode   = mode_q;
    c_de     = de_q;
    c_cursor = cursor_q;
    c_ul     = ul_q;
    c_blink  = blink_q;
    c_attr   = attr_q;
    c_dot    = shift_q[15];
    if (load) begin
      c_mode   = gfx_mode;
      c_de     = de;
      c_cursor = cursor;
      c_ul     = ul_row;
      c_blink  = blink_en;
      c_attr   = attr;
      c_dot    = load_bits[15];
    end
  end

  always_comb begin
    invisible = (c_attr[6:4] == 3'b000) && (c_attr[2:0] == 3'b000);
    reverse   = (c_attr[6:4] == 3'b111) && (c_attr[2:0] == 3'b000);
    underline = (c_attr[2:0] == 3'b001);
    fg_v = 1'b1;
    fg_i = c_attr[3];
    bg_v = 1'b0;
    bg_i = 1'b0;
    if (reverse) begin
      fg_v = 1'b0;
      fg_i = 1'b0;
      bg_v = 1'b1;
      bg_i = c_attr[7] & ~c_blink;
    end
    pix_v = 1'b0;
    pix_i = 1'b0;
    if (c_mode) begin
      pix_v = c_de & c_dot;
    end else if (!c_de) begin
      pix_v = 1'b0;
    end else if (c_cursor && frame[3]) begin
      pix_v = fg_v;
      pix_i = fg_i;
    end else if (invisible) begin
      pix_v = bg_v;
      pix_i = bg_i;
    end else if (underline && c_ul) begin
      pix_v = fg_v;
      pix_i = fg_i;
    end else if (c_blink && c_attr[7] && frame[4]) begin
      pix_v = bg_v;
      pix_i = bg_i;
    end else begin
      pix_v = c_dot ? fg_v : bg_v;
      pix_i = c_dot ? fg_i : bg_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame     <= 5'd0;
      vsync_q   <= 1'b0;
      shift_q   <= 16'd0;
      remain_q  <= 4'd0;
      mode_q    <= 1'b0;
      de_q      <= 1'b0;
      cursor_q  <= 1'b0;
      ul_q      <= 1'b0;
      blink_q   <= 1'b0;
      attr_q    <= 8'd0;
      video     <= 1'b0;
      intensity <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (vsync && !vsync_q) frame <= frame + 5'd1;
      if (pix_ce) begin
        if (load) begin
          shift_q   <= {load_bits[14:0], 1'b0};
          remain_q  <= gfx_mode ? 4'd15 : 4'd8;
          mode_q    <= gfx_mode;
          de_q      <= de;
          cursor_q  <= cursor;
          ul_q      <= ul_row;
          blink_q   <= blink_en;
          attr_q    <= attr;
          video     <= pix_v;
          intensity <= pix_i;
        end else if (remain_q != 4'd0) begin
          shift_q   <= {shift_q[14:0], 1'b0};
          remain_q  <= remain_q - 4'd1;
          video     <= pix_v;
          intensity <= pix_i;
        end else begin
          video     <= 1'b0;
          intensity <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hgc_pixel.sv
// Directed self-checking bench for hgc_pixel with hand-computed dot sequences.
module tb_hgc_pixel;

  logic        clk = 1'b0;
  logic        reset, pix_ce, load, gfx_mode;
  logic [7:0]  char_code, char_bits, attr;
  logic [15:0] gfx_word;
  logic        de, cursor, ul_row, blink_en, vsync;
  logic        video, intensity;

  int checks = 0;
  int errors = 0;

  hgc_pixel dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .load(load), .gfx_mode(gfx_mode),
    .char_code(char_code), .char_bits(char_bits), .attr(attr), .gfx_word(gfx_word),
    .de(de), .cursor(cursor), .ul_row(ul_row), .blink_en(blink_en), .vsync(vsync),
    .video(video), .intensity(intensity)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: presents a cell with load for one slot, leaving pixel 0 on the outputs.
  task automatic load_cell(input logic gm, input logic [7:0] cc, input logic [7:0] cb,
                           input logic [7:0] at, input logic [15:0] gw,
                           input logic bl, input logic cu, input logic ul);
    gfx_mode = gm; char_code = cc; char_bits = cb; attr = at; gfx_word = gw;
    blink_en = bl; cursor = cu; ul_row = ul; de = 1'b1;
    pix_ce = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_vsync(input int n);
    pix_ce = 1'b0;
    for (int k = 0; k < n; k++) begin
      vsync = 1'b1; step(); step();
      vsync = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_ce = 1'b1; load = 1'b1;
    step(); step();
    checks++;
    if (video !== 1'b0 || intensity !== 1'b0) begin
      errors++; $display("FAIL reset_out got %b%b want 00", video, intensity);
    end
    reset = 1'b0; load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (video !== 1'b0 || intensity !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle slot %0d got %b%b want 00", i, video, intensity);
      end
    end
  endtask

  task automatic test_text();
    logic [8:0] ev = 9'b101001010;
    logic e;
    load_cell(1'b0, 8'h41, 8'hA5, 8'h07, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      e = (i < 9) ? ev[8-i] : 1'b0;
      checks++;
      if (video !== e || intensity !== 1'b0) begin
        errors++; $display("FAIL text_A5 dot %0d got %b%b want %b0", i, video, intensity, e);
      end
      if (i == 2) begin
        pix_ce = 1'b0;
        for (int h = 0; h < 3; h++) begin
          step();
          checks++;
          if (video !== 1'b1) begin
            errors++; $display("FAIL hold_pix_ce cycle %0d got %b want 1", h, video);
          end
        end
        pix_ce = 1'b1;
      end
    end
  endtask

  task automatic test_dot8();
    logic [8:0] ev;
    logic e;
    load_cell(1'b0, 8'hC4, 8'h01, 8'h0F, 16'h0, 1'b0, 1'b0, 1'b0);
    ev = 9'b000000011;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      e = (i < 9) ? ev[8-i] : 1'b0;
      checks++;
      if (video !== e || intensity !== e) begin
        errors++; $display("FAIL dot8_C4 dot %0d got %b%b want %b%b", i, video, intensity, e, e);
      end
    end
    load_cell(1'b0, 8'h41, 8'h01, 8'h0F, 16'h0, 1'b0, 1'b0, 1'b0);
    ev = 9'b000000010;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      e = ev[8-i];
      checks++;
      if (video !== e) begin
        errors++; $display("FAIL dot8_41 dot %0d got %b want %b", i, video, e);
      end
    end
  endtask

  task automatic test_reverse();
    logic [8:0] ev = 9'b000011111;
    logic e;
    load_cell(1'b0, 8'h41, 8'hF0, 8'h70, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      e = ev[8-i];
      checks++;
      if (video !== e || intensity !== 1'b0) begin
        errors++; $display("FAIL reverse_70 dot %0d got %b%b want %b0", i, video, intensity, e);
      end
    end
    load_cell(1'b0, 8'h41, 8'hF0, 8'hF0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      e = ev[8-i];
      checks++;
      if (video !== e || intensity !== e) begin
        errors++; $display("FAIL reverse_F0 dot %0d got %b%b want %b%b", i, video, intensity, e, e);
      end
    end
  endtask

  task automatic test_attr();
    load_cell(1'b0, 8'h41, 8'h00, 8'h01, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      checks++;
      if (video !== 1'b1 || intensity !== 1'b0) begin
        errors++; $display("FAIL underline dot %0d got %b%b want 10", i, video, intensity);
      end
    end
    load_cell(1'b0, 8'h41, 8'hFF, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      checks++;
      if (video !== 1'b0 || intensity !== 1'b0) begin
        errors++; $display("FAIL invisible dot %0d got %b%b want 00", i, video, intensity);
      end
    end
    de = 1'b0; load = 1'b1; attr = 8'h0F; char_bits = 8'hFF;
    step();
    load = 1'b0;
    checks++;
    if (video !== 1'b0) begin
      errors++; $display("FAIL de_low got %b want 0", video);
    end
  endtask

  task automatic test_gfx();
    logic [15:0] ev = 16'h8001;
    logic e;
    load_cell(1'b1, 8'h41, 8'hFF, 8'h0F, 16'h8001, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 19; i++) begin
      if (i > 0) step();
      e = (i < 16) ? ev[15-i] : 1'b0;
      checks++;
      if (video !== e || intensity !== 1'b0) begin
        errors++; $display("FAIL gfx_8001 px %0d got %b%b want %b0", i, video, intensity, e);
      end
    end
    load_cell(1'b1, 8'h41, 8'hFF, 8'h0F, 16'h8001, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      step();
      checks++;
      if (video !== 1'b0) begin
        errors++; $display("FAIL gfx_pre_trunc px %0d got %b want 0", i, video);
      end
    end
    load_cell(1'b1, 8'h41, 8'h00, 8'h00, 16'hC000, 1'b0, 1'b0, 1'b0);
    ev = 16'hC000;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) step();
      e = (i < 16) ? ev[15-i] : 1'b0;
      checks++;
      if (video !== e) begin
        errors++; $display("FAIL gfx_trunc px %0d got %b want %b", i, video, e);
      end
    end
  endtask

  task automatic test_blink();
    logic [8:0] lit9 = 9'b111111110;
    logic e;
    load_cell(1'b0, 8'h41, 8'hFF, 8'h87, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      e = lit9[8-i];
      checks++;
      if (video !== e) begin
        errors++; $display("FAIL blink_f0 dot %0d got %b want %b", i, video, e);
      end
    end
    pulse_vsync(8);
    load_cell(1'b0, 8'h41, 8'hFF, 8'h87, 16'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      checks++;
      if (video !== 1'b1) begin
        errors++; $display("FAIL cursor_f8 dot %0d got %b want 1", i, video);
      end
    end
    pulse_vsync(8);
    load_cell(1'b0, 8'h41, 8'hFF, 8'h87, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      checks++;
      if (video !== 1'b0) begin
        errors++; $display("FAIL blink_f16 dot %0d got %b want 0", i, video);
      end
    end
    load_cell(1'b0, 8'h41, 8'hFF, 8'h87, 16'h0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (video !== 1'b1) begin
      errors++; $display("FAIL blink_disabled_f16 got %b want 1", video);
    end
    pulse_vsync(8);
    load_cell(1'b0, 8'h41, 8'hFF, 8'h87, 16'h0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (video !== 1'b1) begin
      errors++; $display("FAIL cursor_f24 got %b want 1", video);
    end
    pulse_vsync(8);
    load_cell(1'b0, 8'h41, 8'hFF, 8'h87, 16'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (video !== 1'b1) begin
      errors++; $display("FAIL frame_wrap got %b want 1", video);
    end
  endtask

  task automatic test_reset_mid();
    pulse_vsync(16);
    load_cell(1'b0, 8'h41, 8'hFF, 8'h0F, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) step();
    checks++;
    if (video !== 1'b1 || intensity !== 1'b1) begin
      errors++; $display("FAIL pre_reset_dot3 got %b%b want 11", video, intensity);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (video !== 1'b0 || intensity !== 1'b0) begin
      errors++; $display("FAIL reset_mid got %b%b want 00", video, intensity);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (video !== 1'b0 || intensity !== 1'b0) begin
        errors++; $display("FAIL reset_no_pixels slot %0d got %b%b want 00", i, video, intensity);
      end
    end
    load_cell(1'b0, 8'h41, 8'hFF, 8'h87, 16'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (video !== 1'b1) begin
      errors++; $display("FAIL reset_frame_zero got %b want 1", video);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pix_ce = 1'b0; load = 1'b0; gfx_mode = 1'b0;
    char_code = 8'h00; char_bits = 8'h00; attr = 8'h00; gfx_word = 16'h0;
    de = 1'b0; cursor = 1'b0; ul_row = 1'b0; blink_en = 1'b0; vsync = 1'b0;
    test_reset();
    test_text();
    test_dot8();
    test_reverse();
    test_attr();
    test_gfx();
    test_blink();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
